// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: CPU byte writes queue in a small FIFO and are
// shifted out LSB-first on uart_tx, one frame per byte with a 1-clk gap between frames.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DEPTH        = 16,
  parameter int AW           = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          busy,
  output logic          uart_tx
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam int            BW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BAUD_MAX  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg, empty_reg;

  logic [1:0]    state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          tx_reg, tx_next;

  logic          do_pop, do_write, last_clk;

  // A pop frees a slot in the same cycle, so a write is accepted even when full.
  assign do_pop   = (state_reg == IDLE) && !empty_reg;
  assign do_write = wr_en && (!full_reg || do_pop);
  assign last_clk = (baud_reg == BAUD_MAX);

  always_comb begin
    count_next = count_reg;
    case ({do_write, do_pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg  <= count_next;
      full_reg   <= (count_next == CNT_FULL);
      empty_reg  <= (count_next == '0);
    end
  end

  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    case (state_reg)
      IDLE: begin
        if (do_pop) begin
          state_next = START;
          baud_next  = '0;
          shift_next = mem[rd_ptr_reg];
        end
      end
      START: begin
        if (last_clk) begin
          state_next   = DATA;
          baud_next    = '0;
          bit_idx_next = '0;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      DATA: begin
        if (last_clk) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
      default: begin
        if (last_clk) begin
          state_next = IDLE;
          baud_next  = '0;
        end else begin
          baud_next = baud_reg + BAUD_ONE;
        end
      end
    endcase
  end

  // Line level follows the state one clock later, from a flop, so uart_tx never glitches.
  always_comb begin
    tx_next = 1'b1;
    case (state_reg)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_reg[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
    end
  end

  assign full    = full_reg;
  assign empty   = empty_reg;
  assign count   = count_reg;
  assign busy    = (state_reg != IDLE);
  assign uart_tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table for the write/pop handshake, hand-written
// sequences for reset, frame timing, overflow and simultaneous push/pop, plus a line decoder.
module tb_uart_tx_fifo;

  localparam int CPB = 87;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       busy;
  logic       uart_tx;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(16), .AW(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .busy    (busy),
    .uart_tx (uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  // Serial line decoder: samples mid-bit on falling clock edges.
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         frame_err = 0;

  initial begin : decoder
    logic [7:0] b;
    logic       ok;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        start_q.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        ok = (uart_tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1) ok = 1'b0;
        if (!ok) frame_err++;
        rx_q.push_back(b);
      end
    end
  end

  task automatic clear_rx();
    rx_q.delete();
    start_q.delete();
    frame_err = 0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    check("rx_frames_received", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic [4:0] exp_count;
    logic       exp_empty;
    logic       exp_busy;
    logic       exp_tx;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int         mism;
    int         first_bad;
    int         c;
    int         b;
    logic       exp_tx;
    logic [7:0] pat;
    logic [7:0] exp_bytes[$];
    string      msg;

    // Burst "ABC" on consecutive clocks from an idle, empty transmitter.
    vecs[0] = '{1'b1, 8'h41, 5'd1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 8'h42, 5'd1, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'h43, 5'd2, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 5'd2, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 5'd2, 1'b0, 1'b1, 1'b0};

    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_uart_tx", 32'(uart_tx), 32'd1);
    check("reset_busy",    32'(busy),    32'd0);
    check("reset_full",    32'(full),    32'd0);
    check("reset_empty",   32'(empty),   32'd1);
    check("reset_count",   32'(count),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-frame: line must go high without waiting for a clock edge.
    write_byte(8'h00);
    write_byte(8'h12);
    repeat (300) @(posedge clk);
    #1;
    check("midframe_line_low", 32'(uart_tx), 32'd0);
    check("midframe_count",    32'(count),   32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_uart_tx", 32'(uart_tx), 32'd1);
    check("async_rst_busy",    32'(busy),    32'd0);
    check("async_rst_count",   32'(count),   32'd0);
    check("async_rst_empty",   32'(empty),   32'd1);
    check("async_rst_full",    32'(full),    32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check("post_rst_idle_line", 32'(uart_tx), 32'd1);
    check("post_rst_busy",      32'(busy),    32'd0);
    clear_rx();

    // Single byte 0x55: cycle-exact waveform from the write edge.
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = 8'h55;
    @(posedge clk);
    #1;
    check("single_count_after_wr", 32'(count), 32'd1);
    check("single_busy_after_wr",  32'(busy),  32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    pat       = 8'h55;
    mism      = 0;
    first_bad = -1;
    for (int rel = 1; rel <= 10 * CPB + 2; rel++) begin
      @(posedge clk);
      #1;
      if (rel < 2) begin
        exp_tx = 1'b1;
      end else begin
        b = (rel - 2) / CPB;
        if (b == 0)      exp_tx = 1'b0;
        else if (b <= 8) exp_tx = pat[b-1];
        else             exp_tx = 1'b1;
      end
      if (uart_tx !== exp_tx || busy !== (rel < 10 * CPB + 1)) begin
        mism++;
        if (first_bad < 0) first_bad = rel;
      end
    end
    check("single_waveform_mismatches", 32'(mism), 32'd0);
    if (mism != 0) $display("[TB] first bad cycle after write edge: %0d", first_bad);
    wait_rx(1, 200);
    if (rx_q.size() >= 1) check("single_rx_byte", 32'(rx_q[0]), 32'h55);
    check("single_frame_err", 32'(frame_err), 32'd0);
    clear_rx();
    repeat (10) @(posedge clk);

    // Burst via vector table.
    foreach (vecs[i]) begin
      @(negedge clk);
      wr_en   = vecs[i].wr;
      wr_data = vecs[i].data;
      @(posedge clk);
      #1;
      $sformat(msg, "burst_v%0d_count", i);  check(msg, 32'(count),   32'(vecs[i].exp_count));
      $sformat(msg, "burst_v%0d_empty", i);  check(msg, 32'(empty),   32'(vecs[i].exp_empty));
      $sformat(msg, "burst_v%0d_busy", i);   check(msg, 32'(busy),    32'(vecs[i].exp_busy));
      $sformat(msg, "burst_v%0d_uart_tx", i); check(msg, 32'(uart_tx), 32'(vecs[i].exp_tx));
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_rx(3, 4000);
    if (rx_q.size() >= 3) begin
      check("burst_rx0", 32'(rx_q[0]), 32'h41);
      check("burst_rx1", 32'(rx_q[1]), 32'h42);
      check("burst_rx2", 32'(rx_q[2]), 32'h43);
      check("burst_gap01", 32'(start_q[1] - start_q[0]), 32'(10 * CPB + 1));
      check("burst_gap12", 32'(start_q[2] - start_q[1]), 32'(10 * CPB + 1));
    end
    check("burst_frame_err", 32'(frame_err), 32'd0);
    repeat (100) @(posedge clk);
    clear_rx();

    // Overflow while the line is busy, then write+pop while full.
    write_byte(8'hEE);
    repeat (5) @(posedge clk);
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_data = 8'(i);
      @(posedge clk);
      #1;
      if (i == 14) begin
        check("fill15_count", 32'(count), 32'd15);
        check("fill15_full",  32'(full),  32'd0);
      end
      if (i == 15) begin
        check("fill16_count", 32'(count), 32'd16);
        check("fill16_full",  32'(full),  32'd1);
      end
      if (i == 16) begin
        check("drop17_count", 32'(count), 32'd16);
        check("drop17_full",  32'(full),  32'd1);
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (busy !== 1'b0 && c < 1000);
    check("full_reached_idle", 32'(busy), 32'd0);
    wr_en   = 1'b1;
    wr_data = 8'hAA;
    @(posedge clk);
    #1;
    check("push_pop_full_count", 32'(count), 32'd16);
    check("push_pop_full_full",  32'(full),  32'd1);
    check("push_pop_full_busy",  32'(busy),  32'd1);
    @(negedge clk);
    wr_en = 1'b0;
    exp_bytes.delete();
    exp_bytes.push_back(8'hEE);
    for (int i = 0; i < 16; i++) exp_bytes.push_back(8'(i));
    exp_bytes.push_back(8'hAA);
    wait_rx(18, 20000);
    mism = 0;
    for (int i = 0; i < 18; i++) begin
      if (i >= rx_q.size() || rx_q[i] !== exp_bytes[i]) mism++;
    end
    check("full_sequence_mismatches", 32'(mism), 32'd0);
    check("full_frame_err", 32'(frame_err), 32'd0);
    repeat (100) @(posedge clk);
    #1;
    check("drained_empty", 32'(empty), 32'd1);
    check("drained_count", 32'(count), 32'd0);
    check("drained_busy",  32'(busy),  32'd0);
    clear_rx();

    // CPU-style output with irregular store spacing.
    msg = "Hi!\n";
    for (int i = 0; i < msg.len(); i++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      write_byte(msg[i]);
    end
    wait_rx(msg.len(), 6000);
    mism = 0;
    for (int i = 0; i < msg.len(); i++) begin
      if (i >= rx_q.size() || rx_q[i] !== msg[i]) mism++;
    end
    check("hello_string_mismatches", 32'(mism), 32'd0);
    check("hello_frame_err", 32'(frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
